// File: rtl/venom_launcher.sv
`default_nettype none
// ============================================================================
// Module   : venom_launcher
// Brief    : Multi-slot venom projectile fire controller. Optional autofire
//            is enabled by defining VENOM_AUTOFIRE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module venom_launcher #(
    parameter int NUM_SLOTS = 3,
    parameter int KEY_BYTES = 2,
    parameter int DIR_W     = 2,
    parameter int COOLDOWN  = 4,
    parameter int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    parameter int CNT_W     = $clog2(NUM_SLOTS + 1)
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic [8*KEY_BYTES-1:0]     keycode,
    input  logic [7:0]                 fire_key,
    input  logic                       enable,
    input  logic [DIR_W-1:0]           motion_dir,
    input  logic [NUM_SLOTS-1:0]       collision,
    output logic [NUM_SLOTS-1:0]       slot_moving,
    output logic [NUM_SLOTS*DIR_W-1:0] slot_dir,
    output logic                       fire_pulse,
    output logic [SLOT_W-1:0]          fire_slot,
    output logic [CNT_W-1:0]           free_count,
    output logic                       cooldown_busy
);

    localparam int              CD_W      = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [CD_W-1:0] C_CD_LOAD = CD_W'(COOLDOWN);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FIRED  = 2'd1,
        S_MOVING = 2'd2
    } slot_state_t;

    logic                  r_match_q;
    logic [CD_W-1:0]       r_cooldown;
    logic                  r_fire_pulse;
    logic [SLOT_W-1:0]     r_fire_slot;

    logic                  w_match;
    logic                  w_request;
    logic                  w_accept;
    logic                  w_any_idle;
    logic [SLOT_W-1:0]     w_alloc_idx;
    logic [NUM_SLOTS-1:0]  w_idle_vec;
    logic [CNT_W-1:0]      w_free_count;

    always_comb begin
        w_match = 1'b0;
        for (int i = 0; i < KEY_BYTES; i++) begin
            if (keycode[8*i +: 8] == fire_key) begin
                w_match = 1'b1;
            end
        end
        w_match = w_match & (fire_key != 8'h00);
    end

    // Scan from the top down so the lowest-index idle slot wins.
    always_comb begin
        w_any_idle  = 1'b0;
        w_alloc_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (w_idle_vec[i]) begin
                w_any_idle  = 1'b1;
                w_alloc_idx = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        w_free_count = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_free_count = w_free_count + CNT_W'(w_idle_vec[i]);
        end
    end

`ifdef VENOM_AUTOFIRE_EN
    // A held key re-requests whenever cooldown is clear; the edge is implied.
    assign w_request = w_match | (w_match & ~r_match_q);
`else
    assign w_request = w_match & ~r_match_q;
`endif

    assign w_accept = w_request & enable & w_any_idle & (r_cooldown == '0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_match_q    <= 1'b0;
            r_cooldown   <= '0;
            r_fire_pulse <= 1'b0;
            r_fire_slot  <= '0;
        end else begin
            r_match_q    <= w_match;
            r_fire_pulse <= w_accept;
            if (w_accept) begin
                r_fire_slot <= w_alloc_idx;
                r_cooldown  <= C_CD_LOAD;
            end else if (r_cooldown != '0) begin
                r_cooldown <= r_cooldown - CD_W'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            slot_state_t      r_state;
            logic             r_moving;
            logic [DIR_W-1:0] r_dir;

            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    r_state  <= S_IDLE;
                    r_moving <= 1'b0;
                    r_dir    <= '0;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (w_accept && (w_alloc_idx == SLOT_W'(gi))) begin
                                r_state <= S_FIRED;
                                r_dir   <= motion_dir;
                            end
                        end
                        S_FIRED: begin
                            r_state  <= S_MOVING;
                            r_moving <= 1'b1;
                        end
                        S_MOVING: begin
                            if (collision[gi]) begin
                                r_state  <= S_IDLE;
                                r_moving <= 1'b0;
                            end
                        end
                        default: begin
                            r_state  <= S_IDLE;
                            r_moving <= 1'b0;
                        end
                    endcase
                end
            end

            assign w_idle_vec[gi]                = (r_state == S_IDLE);
            assign slot_moving[gi]               = r_moving;
            assign slot_dir[DIR_W*gi +: DIR_W]   = r_dir;
        end
    endgenerate

    assign fire_pulse    = r_fire_pulse;
    assign fire_slot     = r_fire_slot;
    assign free_count    = w_free_count;
    assign cooldown_busy = (r_cooldown != '0);

endmodule
`default_nettype wire

// File: tb/tb_venom_launcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_venom_launcher
// Brief    : Scoreboard bench for venom_launcher (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_venom_launcher;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [15:0] keycode;
    logic [7:0]  fire_key;
    logic        enable;
    logic [1:0]  motion_dir;
    logic [2:0]  collision;
    logic [2:0]  slot_moving;
    logic [5:0]  slot_dir;
    logic        fire_pulse;
    logic [1:0]  fire_slot;
    logic [1:0]  free_count;
    logic        cooldown_busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         slot;
        logic [1:0] dir;
    } fire_t;

    fire_t sb[$];

    venom_launcher dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .keycode       (keycode),
        .fire_key      (fire_key),
        .enable        (enable),
        .motion_dir    (motion_dir),
        .collision     (collision),
        .slot_moving   (slot_moving),
        .slot_dir      (slot_dir),
        .fire_pulse    (fire_pulse),
        .fire_slot     (fire_slot),
        .free_count    (free_count),
        .cooldown_busy (cooldown_busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One-cycle key press in the upper keycode byte.
    task automatic press(input logic [1:0] dir, input bit acc, input int slot);
        fire_t e;
        motion_dir = dir;
        keycode    = 16'h2C00;
        if (acc) begin
            e.slot = slot;
            e.dir  = dir;
            sb.push_back(e);
        end
        tick();
        keycode = 16'h0000;
        tick();
    endtask

    task automatic clear_all();
        collision = 3'b111;
        tick();
        collision = 3'b000;
    endtask

    always @(negedge Clk) begin
        fire_t e;
        if (fire_pulse) begin
            if (sb.size() == 0) begin
                check("unexpected_fire", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("fire_slot", 32'(fire_slot), 32'(e.slot));
                check("fire_dir", 32'(slot_dir[2*e.slot +: 2]), 32'(e.dir));
            end
        end
    end

    initial begin
        Reset_n    = 1'b0;
        keycode    = 16'h0000;
        fire_key   = 8'h2C;
        enable     = 1'b1;
        motion_dir = 2'b00;
        collision  = 3'b000;
        repeat (3) tick();
        check("rst_moving", 32'(slot_moving), 32'd0);
        check("rst_free", 32'(free_count), 32'd3);
        check("rst_pulse", 32'(fire_pulse), 32'd0);
        check("rst_slot", 32'(fire_slot), 32'd0);
        check("rst_cd", 32'(cooldown_busy), 32'd0);
        check("rst_dir", 32'(slot_dir), 32'd0);
        Reset_n = 1'b1;
        tick();

        // Single fire latency and direction latch
        press(2'b10, 1'b1, 0);
        check("lat_moving", 32'(slot_moving), 32'b001);
        check("lat_dir", 32'(slot_dir[1:0]), 32'b10);
        check("lat_free", 32'(free_count), 32'd2);
        repeat (4) tick();

        // Fill all slots, then a dropped press on full
        press(2'b01, 1'b1, 1);
        repeat (4) tick();
        press(2'b11, 1'b1, 2);
        repeat (4) tick();
        check("full_free", 32'(free_count), 32'd0);
        check("full_moving", 32'(slot_moving), 32'b111);
        press(2'b00, 1'b0, 0);
        check("full_no_cd", 32'(cooldown_busy), 32'd0);
        collision = 3'b010;
        tick();
        collision = 3'b000;
        check("coll_moving", 32'(slot_moving), 32'b101);
        check("coll_free", 32'(free_count), 32'd1);
        press(2'b01, 1'b1, 1);
        repeat (4) tick();

        // Cooldown blocks an early second press
        clear_all();
        check("clr_free", 32'(free_count), 32'd3);
        press(2'b10, 1'b1, 0);
        check("cd_busy", 32'(cooldown_busy), 32'd1);
        press(2'b11, 1'b0, 0);
        repeat (4) tick();
        check("cd_done", 32'(cooldown_busy), 32'd0);
        press(2'b01, 1'b1, 1);
        repeat (4) tick();

        // Disabled game: no fire, collisions still honoured
        enable = 1'b0;
        press(2'b00, 1'b0, 0);
        check("dis_free", 32'(free_count), 32'd1);
        collision = 3'b001;
        tick();
        collision = 3'b000;
        check("dis_coll", 32'(slot_moving), 32'b010);
        enable   = 1'b1;
        fire_key = 8'h00;
        keycode  = 16'h0000;
        repeat (3) tick();
        check("zero_key_free", 32'(free_count), 32'd2);
        fire_key = 8'h2C;
        repeat (4) tick();

        // Held key in the low byte
        clear_all();
        begin
            fire_t e;
            e.dir = 2'b11;
`ifdef VENOM_AUTOFIRE_EN
            for (int s = 0; s < 3; s++) begin
                e.slot = s;
                sb.push_back(e);
            end
`else
            e.slot = 0;
            sb.push_back(e);
`endif
        end
        motion_dir = 2'b11;
        keycode    = 16'h002C;
        repeat (20) tick();
        keycode = 16'h0000;
        tick();
`ifdef VENOM_AUTOFIRE_EN
        check("hold_free", 32'(free_count), 32'd0);
`else
        check("hold_free", 32'(free_count), 32'd2);
`endif
        repeat (4) tick();

        // Asynchronous reset with two slots in flight
        clear_all();
        press(2'b10, 1'b1, 0);
        repeat (4) tick();
        press(2'b01, 1'b1, 1);
        tick();
        check("pre_rst_moving", 32'(slot_moving), 32'b011);
        Reset_n = 1'b0;
        #1;
        check("arst_moving", 32'(slot_moving), 32'd0);
        check("arst_free", 32'(free_count), 32'd3);
        check("arst_pulse", 32'(fire_pulse), 32'd0);
        tick();
        Reset_n = 1'b1;
        tick();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
